// File: rtl/aes_pkg.sv
// aes_pkg: shared AES typedefs, rcon table and GF(2^8) helpers for the key generators.
package aes_pkg;
  typedef logic [31:0] word_t;
  typedef logic [127:0] key_t;
  typedef enum logic {IDLE, EMIT} state_t;
  localparam int NUM_ROUNDS_AES128 = 10;
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p ^= b[i] ? x : 8'h00;
      x = xtime(x);
    end
    return p;
  endfunction
  function automatic logic [7:0] mul9(input logic [7:0] b);
    return gf_mul(b, 8'h09);
  endfunction
  function automatic logic [7:0] mul11(input logic [7:0] b);
    return gf_mul(b, 8'h0b);
  endfunction
  function automatic logic [7:0] mul13(input logic [7:0] b);
    return gf_mul(b, 8'h0d);
  endfunction
  function automatic logic [7:0] mul14(input logic [7:0] b);
    return gf_mul(b, 8'h0e);
  endfunction
  // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gf_mul(r, r);
      if (i != 0) r = gf_mul(r, x);
    end
    return r;
  endfunction
  function automatic word_t rcon(input logic [3:0] i);
    logic [7:0] r;
    r = 8'h01;
    for (int k = 2; k <= 10; k++) if (k <= int'(i)) r = xtime(r);
    return {r, 24'h000000};
  endfunction
  function automatic word_t inv_mix_col(input word_t w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {mul14(a0) ^ mul11(a1) ^ mul13(a2) ^ mul9(a3),
            mul9(a0) ^ mul14(a1) ^ mul11(a2) ^ mul13(a3),
            mul13(a0) ^ mul9(a1) ^ mul14(a2) ^ mul11(a3),
            mul11(a0) ^ mul13(a1) ^ mul9(a2) ^ mul14(a3)};
  endfunction
endpackage

// File: rtl/aes_inv_key_step.sv
// aes_inv_key_step: derives round key i-1 from round key i (w0 in bits 127:96).
module aes_inv_key_step
  import aes_pkg::*;
(
  input  key_t       key,
  input  logic [3:0] round,
  output key_t       prev
);
  word_t w0, w1, w2, w3, w3n, rot, sub;
  assign {w0, w1, w2, w3} = key;
  assign w3n = w3 ^ w2;
  assign rot = {w3n[23:0], w3n[31:24]};
  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (.a(rot[8*b +: 8]), .s(sub[8*b +: 8]));
  end
  assign prev = {w0 ^ sub ^ rcon(round), w1 ^ w0, w2 ^ w1, w3n};
endmodule

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES S-box cell (GF inverse followed by the affine map).
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] s
);
  logic [7:0] inv;
  assign inv = gf_inv(a);
  assign s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
             {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

// File: rtl/aes_inv_key_sched.sv
// aes_inv_key_sched: emits AES-128 round keys 10..0 from the final round key, one per handshake.
// Define AES_EQ_INV_KEY_EN to output InvMixColumns'd keys for rounds 1..9 (equivalent inverse cipher).
module aes_inv_key_sched
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = NUM_ROUNDS_AES128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         key_valid,
  input  logic         key_ready,
  output logic [127:0] key_out,
  output logic [3:0]   round_out,
  output logic         done
);
  state_t state, state_d;
  key_t key_q, key_d, prev;
  logic [3:0] round_q, round_d;
  logic done_d;
  aes_inv_key_step u_step (.key(key_q), .round(round_q), .prev(prev));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      key_q <= '0;
      round_q <= '0;
      done <= 1'b0;
    end else begin
      state <= state_d;
      key_q <= key_d;
      round_q <= round_d;
      done <= done_d;
    end
  end
  always_comb begin
    state_d = state;
    key_d = key_q;
    round_d = round_q;
    done_d = 1'b0;
    if (state == IDLE && start) begin
      key_d = key_in;
      round_d = 4'(NUM_ROUNDS);
      state_d = EMIT;
    end else if (state == EMIT && key_ready && round_q != 4'd0) begin
      key_d = prev;
      round_d = round_q - 4'd1;
    end else if (state == EMIT && key_ready) begin
      state_d = IDLE;
      done_d = 1'b1;
    end
  end
  assign busy = state == EMIT;
  assign key_valid = busy;
  assign round_out = round_q;
`ifdef AES_EQ_INV_KEY_EN
  key_t imc;
  assign imc = {inv_mix_col(key_q[127:96]), inv_mix_col(key_q[95:64]),
                inv_mix_col(key_q[63:32]), inv_mix_col(key_q[31:0])};
  assign key_out = (round_q != 4'd0 && round_q != 4'(NUM_ROUNDS)) ? imc : key_q;
`else
  assign key_out = key_q;
`endif
endmodule

// File: tb/tb_aes_inv_key_sched.sv
// tb_aes_inv_key_sched: random-stimulus bench against a forward-expansion reference model.
module tb_aes_inv_key_sched;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, key_ready = 1'b0;
  logic [127:0] key_in = '0;
  logic busy, key_valid, done;
  logic [127:0] key_out;
  logic [3:0] round_out;
  int total = 0, bad = 0;
  logic [127:0] ks[0:10];
  logic [7:0] sb[256];
  int exp_rd = 0;
  bit exp_valid = 0, exp_done = 0;
  localparam logic [127:0] FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  aes_inv_key_sched dut (.clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in), .busy(busy),
    .key_valid(key_valid), .key_ready(key_ready), .key_out(key_out), .round_out(round_out),
    .done(done));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // polynomial product, then reduction modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p ^= 15'(a) << i;
    for (int i = 14; i >= 8; i--) if (p[i]) p ^= 15'h11b << (i - 8);
    return p[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8];
      sb[x] = s ^ 8'h63;
    end
  endtask

  // standard forward key expansion from round-0 key; ks[r] = round key r
  task automatic expand(input logic [127:0] k0);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0] rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k0[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] exp_out(input int r);
    logic [127:0] k;
    k = ks[r];
`ifdef AES_EQ_INV_KEY_EN
    if (r >= 1 && r <= 9) begin
      logic [7:0] c[4];
      logic [7:0] a[4];
      logic [7:0] o;
      c = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
      for (int col = 0; col < 4; col++) begin
        for (int j = 0; j < 4; j++) a[j] = ks[r][127 - 32*col - 8*j -: 8];
        for (int i = 0; i < 4; i++) begin
          o = 8'h00;
          for (int j = 0; j < 4; j++) o ^= gm(a[j], c[(j - i + 4) % 4]);
          k[127 - 32*col - 8*i -: 8] = o;
        end
      end
    end
`endif
    return k;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_ctrl", {busy, key_valid, done, round_out}, '0);
      chk("reset_key", key_out, '0);
      exp_valid = 0;
      exp_done = 0;
    end else begin
      chk("key_valid", key_valid, exp_valid);
      chk("busy", busy, exp_valid);
      chk("done", done, exp_done);
      if (exp_valid) begin
        chk("round_out", round_out, exp_rd);
        chk("key_out", key_out, exp_out(exp_rd));
      end
      exp_done = 0;
      if (exp_valid && key_ready) begin
        if (exp_rd == 0) begin
          exp_valid = 0;
          exp_done = 1;
        end else exp_rd--;
      end else if (!exp_valid && start) begin
        exp_valid = 1;
        exp_rd = 10;
      end
    end
  end

  task automatic run_seq(input logic [127:0] k0, input bit bp, input bit pulse);
    bit ok;
    ok = 0;
    expand(k0);
    key_in = ks[10];
    start = 1'b1;
    key_ready = bp ? 1'($urandom % 2) : 1'b1;
    for (int c = 0; c < 400 && !ok; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) chk("first_valid", {key_valid, round_out}, {1'b1, 4'd10});
      if (done) ok = 1;
      start = pulse && key_valid && (round_out == 4'd7 || round_out == 4'd3);
      key_in = {$urandom, $urandom, $urandom, $urandom};
      key_ready = bp ? 1'($urandom % 2) : 1'b1;
    end
    if (!ok) chk("done_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    bit hit;
    build_sbox();
    chk("sbox_00", sb[8'h00], 8'h63);
    chk("sbox_53", sb[8'h53], 8'hed);
    expand(FIPS);
    chk("model_r10", ks[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("model_r9", ks[9], 128'hac7766f319fadc2128d12941575c006e);
    chk("model_r1", ks[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("model_r0", ks[0], FIPS);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    run_seq(FIPS, 0, 0);
    run_seq(FIPS, 1, 0);
    repeat (2) @(posedge clk);
    #1;
    run_seq({$urandom, $urandom, $urandom, $urandom}, 0, 1);
    run_seq({$urandom, $urandom, $urandom, $urandom}, 1, 1);
    repeat (2) @(posedge clk);
    #1;
    expand({$urandom, $urandom, $urandom, $urandom});
    key_in = ks[10];
    start = 1'b1;
    key_ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    hit = 0;
    for (int c = 0; c < 20 && !hit; c++) begin
      if (key_valid && round_out == 4'd5) hit = 1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    chk("reach_round5", hit, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ctrl", {busy, key_valid, done, round_out}, '0);
    chk("async_rst_key", key_out, '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    run_seq({$urandom, $urandom, $urandom, $urandom}, 1, 0);
    run_seq(FIPS, 0, 0);
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
